bcd_display_sequencer: RTL and testbench
========================================

# bcd_display_sequencer

Time-shares one BCD-range checker and one BCD-to-7-segment decoder across four display digits. On a load strobe it captures four BCD nibbles from the switch bank, then steps the shared decoder through digits 0..3, writing each result into a per-digit output register with a per-digit invalid flag. It sits between the switch inputs and the HEX displays, replacing four parallel decoder/comparator pairs.

## Interface
Parameters:
- `STEP_CYCLES`, default 1: clock cycles spent on each digit, minimum 1.
- `DIGITS`, fixed at 4: number of digit slots. It is not a free parameter.

Ports:
- `CLOCK_50` in 1: the only clock. All state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `SW` in 16: four BCD nibbles. `SW[4k+3:4k]` is digit k.
- `load` in 1: capture request. It is sampled only while `busy` = 0.
- `HEX0`..`HEX3` out 7 each: registered active-low segment patterns, bit order gfedcba.
- `err` out 4: registered. `err[k]` = 1 when the captured digit k was greater than 9.
- `busy` out 1: registered. High while a scan is in progress.
- `done` out 1: registered. One-cycle pulse when a scan completes.

## Operation
- **States:**
  - IDLE: `busy` = 0, `done` = 0.
  - SCAN: `busy` = 1.
  - DONE: `busy` = 0, `done` = 1 for exactly one cycle.
- **IDLE or DONE with `load` = 1:**
  - Capture `SW` into the internal 16-bit `data_q`.
  - Clear `err` to 0.
  - Set digit index `idx` = 0 and prescaler = 0.
  - Go to SCAN.
  - `HEX0`..`HEX3` keep their previous values until each one is overwritten.
- **DONE with `load` = 0:** go to IDLE.
- **SCAN:**
  - The shared datapath always operates on nibble `data_q[4*idx+3 : 4*idx]`.
  - The prescaler counts 0..STEP_CYCLES-1.
  - On the edge where the prescaler equals STEP_CYCLES-1, write the decoded pattern into `HEX[idx]` and the range result into `err[idx]`. Then reset the prescaler and increment `idx`.
  - After writing `idx` = 3, go to DONE.
- **Decode table (active-low gfedcba):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..15 = 0111111 (dash), and the matching `err` bit is set.
- **Range check:** `err` bit = (nibble > 4'd9). This is an unsigned 4-bit compare.
- **`load` while `busy` = 1:** ignored, not queued. `SW` changes during SCAN have no effect, because only `data_q` is used.
- **Register updates:** only the register at the current `idx` changes in a given cycle.
- **Reset, asynchronous, including mid-scan:**
  - `HEX0`..`HEX3` = 7'b1111111 (blank).
  - `err` = 0, `busy` = 0, `done` = 0.
  - State = IDLE, `idx` = 0, prescaler = 0, `data_q` = 0.
  - After release, a new `load` is needed to restart. A partial scan is never resumed.

## Timing
- Edge E0 samples `load` = 1 in IDLE. From E0, `busy` = 1 and `err` = 0.
- `HEX[k]` and `err[k]` update at edge E0 + (k+1)·STEP_CYCLES.
- At E0 + 4·STEP_CYCLES, `HEX3` is written, `busy` falls and `done` rises. `done` falls at the next edge.
- Latency from load edge to `done` = 4·STEP_CYCLES cycles.
- A new load can be accepted at the edge where `done` is high.
- With STEP_CYCLES = 1 and `load` held high, a new scan starts every 5 cycles.
- Prescaler width is clog2(STEP_CYCLES), minimum 1 bit, and must not wrap early.

## Test plan
- Reset with `load` = 0:
  - Required response: all HEX = 1111111, `err` = 0000, `busy` = 0, `done` = 0.
- STEP_CYCLES = 1, `SW` = 16'h4321, one-cycle `load`:
  - Required response: `busy` is high for 4 cycles.
  - Updates occur in order: `HEX0` = 1111001, `HEX1` = 0100100, `HEX2` = 0110000, `HEX3` = 0011001.
  - `err` = 0000, and a single `done` pulse occurs 4 cycles after the load edge.
- `SW` = 16'hF9A0:
  - Required response: `HEX0` = 1000000, `HEX1` = 0111111, `HEX2` = 0010000, `HEX3` = 0111111, `err` = 4'b1010.
- STEP_CYCLES = 3, `SW` = 16'h8765, `load`, and `SW` changed to 16'h0000 one cycle later:
  - Required response: writes at +3, +6, +9, +12 cycles.
  - Patterns are for 5, 6, 7, 8 (0010010, 0000010, 1111000, 0000000).
  - `done` is high at +12; a second `load` pulsed during SCAN is ignored.
- Reset asserted between the `HEX1` and `HEX2` writes, then released:
  - Required response: immediate blank/zero state, no `done` pulse, and the state remains IDLE until the next `load`.
- `load` held high continuously with `SW` = 16'h9999:
  - Required response: a new scan starts every 5 cycles (capture on the `done` edge).
  - All HEX = 0010000, `err` = 0000, and `done` pulses every 5 cycles.

Source files
------------

// File: rtl/bcd_display_sequencer.sv
// rtl/bcd_display_sequencer.sv - time-shared BCD range check and 7-segment decode for four digits
//
// Purpose:
//   Captures four BCD nibbles on a load strobe, then walks one shared
//   range checker / segment decoder across digits 0..3, spending
//   STEP_CYCLES clocks on each digit and writing the result into that
//   digit's output register.
//
// Ports:
//   CLOCK_50  in   clock, all state changes on its rising edge
//   reset     in   asynchronous active-high reset
//   SW        in   [15:0] four BCD nibbles, SW[4k+3:4k] is digit k
//   load      in   capture request, honoured only while busy is low
//   HEX0..3   out  [6:0] registered active-low segments, order gfedcba
//   err       out  [3:0] registered, err[k] set when digit k was above 9
//   busy      out  registered, high during a scan
//   done      out  registered, one-cycle pulse when a scan completes

module bcd_display_sequencer #(
  parameter int STEP_CYCLES = 1
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [15:0] SW,
  input  logic        load,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [3:0]  err,
  output logic        busy,
  output logic        done
);

  localparam int DIGITS = 4;
  // A single-cycle step still needs a 1-bit prescaler so the compare is legal.
  localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(STEP_CYCLES - 1);
  localparam logic [1:0]    IDX_LAST = 2'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [15:0]   data_q;
  logic [1:0]    idx;
  logic [PW-1:0] pre;
  logic [6:0]    hex_q [DIGITS];

  logic          capture;
  logic          step_last;
  logic          write_en;
  logic [3:0]    nibble;
  logic [6:0]    seg;
  logic          nib_err;

  // Shared datapath: always looks at the nibble selected by idx.
  assign nibble  = data_q[{idx, 2'b00} +: 4];
  assign nib_err = (nibble > 4'd9);

  always_comb begin
    seg = 7'b0111111;
    case (nibble)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b0111111;
    endcase
  end

  assign step_last = (pre == PRE_LAST);

  always_comb begin
    state_n  = state;
    capture  = 1'b0;
    write_en = 1'b0;
    case (state)
      S_IDLE: begin
        if (load) begin
          capture = 1'b1;
          state_n = S_SCAN;
        end
      end
      S_SCAN: begin
        if (step_last) begin
          write_en = 1'b1;
          if (idx == IDX_LAST) begin
            state_n = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Back-to-back scans: a load seen here restarts without passing IDLE.
        if (load) begin
          capture = 1'b1;
          state_n = S_SCAN;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      data_q <= 16'h0000;
      idx    <= 2'd0;
      pre    <= '0;
      err    <= 4'b0000;
      for (int k = 0; k < DIGITS; k++) begin
        hex_q[k] <= 7'b1111111;
      end
    end else begin
      state <= state_n;
      busy  <= (state_n == S_SCAN);
      done  <= (state_n == S_DONE);
      if (capture) begin
        data_q <= SW;
        err    <= 4'b0000;
        idx    <= 2'd0;
        pre    <= '0;
      end else if (state == S_SCAN) begin
        if (write_en) begin
          hex_q[idx] <= seg;
          err[idx]   <= nib_err;
          pre        <= '0;
          idx        <= idx + 2'd1;
        end else begin
          pre <= pre + 1'b1;
        end
      end
    end
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];

endmodule

// File: tb/tb_bcd_display_sequencer.sv
// tb/tb_bcd_display_sequencer.sv - directed scoreboard bench for bcd_display_sequencer
//
// Purpose:
//   Drives two instances (one decode step per cycle, three cycles per step)
//   and checks reset state, per-digit write timing, decode/err results,
//   ignored loads, mid-scan reset and back-to-back scans.
//
// Ports: none (top-level bench).

module tb_bcd_display_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sw;
  logic        load1;
  logic        load3;

  logic [6:0]  a_hex0, a_hex1, a_hex2, a_hex3;
  logic [3:0]  a_err;
  logic        a_busy, a_done;
  logic [6:0]  b_hex0, b_hex1, b_hex2, b_hex3;
  logic [3:0]  b_err;
  logic        b_busy, b_done;

  logic        sel;
  logic [6:0]  o_hex [4];
  logic [3:0]  o_err;
  logic        o_busy;
  logic        o_done;

  logic [6:0]  prev [2][4];
  logic [31:0] exp_q [$];

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  bcd_display_sequencer #(.STEP_CYCLES(1)) dut1 (
    .CLOCK_50 (clk),
    .reset    (reset),
    .SW       (sw),
    .load     (load1),
    .HEX0     (a_hex0),
    .HEX1     (a_hex1),
    .HEX2     (a_hex2),
    .HEX3     (a_hex3),
    .err      (a_err),
    .busy     (a_busy),
    .done     (a_done)
  );

  bcd_display_sequencer #(.STEP_CYCLES(3)) dut3 (
    .CLOCK_50 (clk),
    .reset    (reset),
    .SW       (sw),
    .load     (load3),
    .HEX0     (b_hex0),
    .HEX1     (b_hex1),
    .HEX2     (b_hex2),
    .HEX3     (b_hex3),
    .err      (b_err),
    .busy     (b_busy),
    .done     (b_done)
  );

  always_comb begin
    o_hex[0] = sel ? b_hex0 : a_hex0;
    o_hex[1] = sel ? b_hex1 : a_hex1;
    o_hex[2] = sel ? b_hex2 : a_hex2;
    o_hex[3] = sel ? b_hex3 : a_hex3;
    o_err    = sel ? b_err  : a_err;
    o_busy   = sel ? b_busy : a_busy;
    o_done   = sel ? b_done : a_done;
  end

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic set_load(input logic v);
    if (sel) load3 = v;
    else     load1 = v;
  endtask

  task automatic scan_check(input logic [15:0] v, input int step,
                            input bit change_sw, input bit extra_load);
    logic [6:0]  eh [4];
    logic [3:0]  ee;
    logic [31:0] sb;
    for (int k = 0; k < 4; k++) begin
      eh[k] = seg_of(v[4*k +: 4]);
      ee[k] = (v[4*k +: 4] > 4'd9);
    end
    exp_q.push_back({eh[3], eh[2], eh[1], eh[0], ee});
    sw = v;
    set_load(1'b1);
    @(negedge clk);
    set_load(1'b0);
    chk($sformatf("start_busy_%h", v), {31'd0, o_busy}, 32'd1);
    chk($sformatf("start_err_%h", v), {28'd0, o_err}, 32'd0);
    if (change_sw) sw = 16'h0000;
    for (int c = 1; c <= 4 * step; c++) begin
      if (extra_load && c == 2) set_load(1'b1);
      if (extra_load && c == 3) set_load(1'b0);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (c == (k + 1) * step) begin
          chk($sformatf("hex%0d_%h", k, v), {25'd0, o_hex[k]}, {25'd0, eh[k]});
          chk($sformatf("err%0d_%h", k, v), {31'd0, o_err[k]}, {31'd0, ee[k]});
          chk($sformatf("busy_c%0d_%h", c, v), {31'd0, o_busy}, {31'd0, (c < 4 * step)});
          prev[sel][k] = eh[k];
        end else if (step > 1 && c == (k + 1) * step - 1) begin
          chk($sformatf("hold%0d_%h", k, v), {25'd0, o_hex[k]}, {25'd0, prev[sel][k]});
        end
      end
    end
    chk($sformatf("done_hi_%h", v), {31'd0, o_done}, 32'd1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      sb = exp_q.pop_front();
      chk($sformatf("final_%h", v), {o_hex[3], o_hex[2], o_hex[1], o_hex[0], o_err}, sb);
    end
    @(negedge clk);
    chk($sformatf("done_lo_%h", v), {31'd0, o_done}, 32'd0);
    chk($sformatf("idle_busy_%h", v), {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    sel   = 1'b0;
    reset = 1'b1;
    load1 = 1'b0;
    load3 = 1'b0;
    sw    = 16'h0000;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++)
        prev[d][k] = 7'b1111111;

    // Reset state of both instances.
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      #0;
      chk($sformatf("rst_hex_d%0d", d), {4'd0, o_hex[3], o_hex[2], o_hex[1], o_hex[0]}, 32'h0FFFFFFF);
      chk($sformatf("rst_ctl_d%0d", d), {26'd0, o_err, o_busy, o_done}, 32'd0);
    end

    // Single-cycle steps.
    sel = 1'b0;
    #0;
    scan_check(16'h4321, 1, 1'b0, 1'b0);
    scan_check(16'hF9A0, 1, 1'b0, 1'b0);

    // Three cycles per digit, SW changed after capture, extra load mid-scan.
    sel = 1'b1;
    #0;
    scan_check(16'h8765, 3, 1'b1, 1'b1);

    // Reset between the HEX1 and HEX2 writes.
    sel = 1'b0;
    #0;
    sw    = 16'h5555;
    load1 = 1'b1;
    @(negedge clk);
    load1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_hex1_written", {25'd0, o_hex[1]}, {25'd0, 7'b0010010});
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_hex", {4'd0, o_hex[3], o_hex[2], o_hex[1], o_hex[0]}, 32'h0FFFFFFF);
    chk("mid_rst_ctl", {26'd0, o_err, o_busy, o_done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++)
        prev[d][k] = 7'b1111111;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst_c%0d", c), {30'd0, o_busy, o_done}, 32'd0);
    end
    chk("post_rst_hex", {4'd0, o_hex[3], o_hex[2], o_hex[1], o_hex[0]}, 32'h0FFFFFFF);

    // Load held high: new scan every 5 cycles.
    sw    = 16'h9999;
    load1 = 1'b1;
    @(negedge clk);
    chk("held_start_busy", {31'd0, o_busy}, 32'd1);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      chk($sformatf("held_done_c%0d", c), {31'd0, o_done}, {31'd0, (c % 5 == 4)});
    end
    load1 = 1'b0;
    chk("held_hex", {4'd0, o_hex[3], o_hex[2], o_hex[1], o_hex[0]},
        {4'd0, 7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000});
    chk("held_err", {28'd0, o_err}, 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
